// File: rtl/tinyalu_pkg.sv
// Shared TinyALU types: operation codes, command/response records and op
// classification helpers used by the command driver and its FIFO.
package tinyalu_pkg;

   typedef enum logic [2:0] {
      NO_OP  = 3'b000,
      ADD_OP = 3'b001,
      AND_OP = 3'b010,
      XOR_OP = 3'b011,
      MUL_OP = 3'b100,
      RST_OP = 3'b111
   } operation_t;

   // op is kept as a raw code so the illegal encodings 101/110 survive the trip
   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
   } cmd_t;

   typedef struct packed {
      logic [2:0]  op;
      logic [15:0] result;
      logic        err;
   } rsp_t;

   localparam int CMD_W = $bits(cmd_t);

   function automatic logic is_illegal_op(input logic [2:0] op);
      return (op == 3'b101) || (op == 3'b110);
   endfunction

   function automatic logic drives_alu_start(input logic [2:0] op);
      return !is_illegal_op(op) && (op != RST_OP);
   endfunction

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO holding pending ALU commands.
// Pointers carry one extra wrap bit to tell full from empty.
module tinyalu_cmd_fifo
   import tinyalu_pkg::*;
#(
   parameter int WIDTH = CMD_W,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop_s  = pop_i && !empty_o;
   // a full FIFO still takes a write when the head leaves in the same cycle
   assign do_push_s = push_i && (!full_o || do_pop_s);
   assign data_o    = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer advance
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // Pointer registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/tinyalu_cmd_driver.sv
// Command driver in front of the TinyALU: buffers commands, runs one ALU
// operation at a time via start/done, and returns op/result/err responses.
module tinyalu_cmd_driver
   import tinyalu_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int DONE_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   input  logic [2:0]  cmd_op,
   output logic        alu_start,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [2:0]  alu_op,
   output logic        alu_reset_n,
   input  logic        alu_done,
   input  logic [15:0] alu_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [2:0]  rsp_op,
   output logic [15:0] rsp_result,
   output logic        rsp_err,
   output logic        busy
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_RSTA  = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   localparam int              CNT_W   = $clog2(DONE_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(DONE_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [2:0]       state_q, state_d;
   logic             alive_q;
   logic             alu_start_q, alu_start_d;
   logic [7:0]       alu_a_q, alu_a_d;
   logic [7:0]       alu_b_q, alu_b_d;
   logic [2:0]       alu_op_q, alu_op_d;
   logic             alu_reset_n_q, alu_reset_n_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rsp_valid_q, rsp_valid_d;
   rsp_t             rsp_q, rsp_d;

   cmd_t             fifo_in_s;
   cmd_t             fifo_out_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic             push_s;
   logic             pop_s;

   // alive_q holds cmd_ready low until the first clock after reset release
   assign cmd_ready = alive_q && !fifo_full_s;
   assign push_s    = cmd_valid && cmd_ready;
   assign pop_s     = (state_q == S_IDLE) && !fifo_empty_s;
   assign fifo_in_s = {cmd_a, cmd_b, cmd_op};

   tinyalu_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_s),
      .data_i  (fifo_in_s),
      .pop_i   (pop_s),
      .data_o  (fifo_out_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s)
   );

   // Sequencing FSM, timeout counter and response capture
   always_comb begin
      state_d       = state_q;
      alu_start_d   = alu_start_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      alu_op_d      = alu_op_q;
      alu_reset_n_d = 1'b1;
      cnt_d         = cnt_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_d         = rsp_q;
      case (state_q)
         S_IDLE: begin
            if (pop_s) begin
               state_d     = S_ISSUE;
               alu_a_d     = fifo_out_s.a;
               alu_b_d     = fifo_out_s.b;
               alu_op_d    = fifo_out_s.op;
               alu_start_d = drives_alu_start(fifo_out_s.op);
            end else begin
               state_d     = S_IDLE;
            end
         end
         S_ISSUE: begin
            alu_start_d = 1'b0;
            rsp_d       = '{op: alu_op_q, result: 16'h0000, err: 1'b0};
            case (alu_op_q)
               NO_OP: begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
               end
               RST_OP: begin
                  state_d       = S_RSTA;
                  alu_reset_n_d = 1'b0;
               end
               ADD_OP, AND_OP, XOR_OP, MUL_OP: begin
                  state_d     = S_WAIT;
                  alu_start_d = 1'b1;
                  cnt_d       = '0;
               end
               default: begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_d.err   = 1'b1;
               end
            endcase
         end
         S_WAIT: begin
            if (alu_done) begin
               state_d     = S_RESP;
               alu_start_d = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_d       = '{op: alu_op_q, result: alu_result, err: 1'b0};
            end else if (cnt_q == CNT_TO) begin
               state_d     = S_RESP;
               alu_start_d = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_d       = '{op: alu_op_q, result: 16'h0000, err: 1'b1};
            end else begin
               cnt_d       = cnt_q + CNT_ONE;
            end
         end
         S_RSTA: begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_d       = '{op: alu_op_q, result: 16'h0000, err: 1'b0};
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
            end else begin
               state_d     = S_RESP;
            end
         end
         default: begin
            state_d     = S_IDLE;
            alu_start_d = 1'b0;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops start and ALU reset at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         alive_q       <= 1'b0;
         alu_start_q   <= 1'b0;
         alu_a_q       <= 8'h00;
         alu_b_q       <= 8'h00;
         alu_op_q      <= 3'b000;
         alu_reset_n_q <= 1'b0;
         cnt_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_q         <= '0;
      end else begin
         state_q       <= state_d;
         alive_q       <= 1'b1;
         alu_start_q   <= alu_start_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_op_q      <= alu_op_d;
         alu_reset_n_q <= alu_reset_n_d;
         cnt_q         <= cnt_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_q         <= rsp_d;
      end
   end

   assign alu_start   = alu_start_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign alu_reset_n = alu_reset_n_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_op      = rsp_q.op;
   assign rsp_result  = rsp_q.result;
   assign rsp_err     = rsp_q.err;
   assign busy        = !fifo_empty_s || (state_q != S_IDLE);

endmodule
